// File: rtl/rf_pkg.sv
// rf_pkg: default sizes and shared index/data types for the multi-port register file.
package rf_pkg;
    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);
    typedef logic [RF_AW-1:0] rf_idx_t;
    typedef logic [RF_DW-1:0] rf_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with flush > set > clear priority,
// plus per-read-port busy masked by same-cycle write-back.
module rf_scoreboard import rf_pkg::*; #(
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_RD*AW-1:0] rd_sel_i,
    output logic [NUM_RD-1:0]    rd_busy_o,
    input  logic [1:0]           wr_en_i,
    input  logic [2*AW-1:0]      wr_sel_i,
    input  logic                 sb_set_en_i,
    input  logic [AW-1:0]        sb_set_sel_i,
    input  logic                 sb_flush_i,
    output logic [DEPTH-1:0]     busy_vec_o
);
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // Applied lowest priority first so later assignments override.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < 2; p++)
            if (wr_en_i[p]) w_busy_nxt[wr_sel_i[p*AW +: AW]] = 1'b0;
        if (sb_set_en_i) w_busy_nxt[sb_set_sel_i] = 1'b1;
        if (sb_flush_i) w_busy_nxt = '0;
        if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) r_busy <= '0;
        else r_busy <= w_busy_nxt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_sel;
        logic          w_wb;
        assign w_sel = rd_sel_i[k*AW +: AW];
        assign w_wb  = (wr_en_i[0] && wr_sel_i[0 +: AW] == w_sel) ||
                       (wr_en_i[1] && wr_sel_i[AW +: AW] == w_sel);
        assign rd_busy_o[k] = r_busy[w_sel] & ~w_wb;
    end

    assign busy_vec_o = r_busy;
endmodule

// File: rtl/rf_mp.sv
// rf_mp: multi-read, dual-write register file with write-first bypass,
// optional hardwired zero register and a RAW busy scoreboard.
module rf_mp import rf_pkg::*; #(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_RD*AW-1:0] rd_sel_i,
    output logic [NUM_RD*DW-1:0] rd_data_o,
    output logic [NUM_RD-1:0]    rd_busy_o,
    input  logic [1:0]           wr_en_i,
    input  logic [2*AW-1:0]      wr_sel_i,
    input  logic [2*DW-1:0]      wr_data_i,
    input  logic                 sb_set_en_i,
    input  logic [AW-1:0]        sb_set_sel_i,
    input  logic                 sb_flush_i,
    output logic [DEPTH-1:0]     busy_vec_o
);
    logic [DW-1:0] r_regs [DEPTH];

    // Port 1 is written last so it wins a same-index collision.
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (wr_en_i[p] && !(ZERO_REG != 0 && wr_sel_i[p*AW +: AW] == '0))
                    r_regs[wr_sel_i[p*AW +: AW]] <= wr_data_i[p*DW +: DW];
        end

    // Reads are gated during reset so a pending write cannot leak through the bypass.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_sel;
        logic          w_hit0;
        logic          w_hit1;
        assign w_sel  = rd_sel_i[k*AW +: AW];
        assign w_hit0 = wr_en_i[0] && wr_sel_i[0 +: AW] == w_sel;
        assign w_hit1 = wr_en_i[1] && wr_sel_i[AW +: AW] == w_sel;
        assign rd_data_o[k*DW +: DW] =
            (!rst_n_i || (ZERO_REG != 0 && w_sel == '0)) ? '0 :
            w_hit1 ? wr_data_i[DW +: DW] :
            w_hit0 ? wr_data_i[0 +: DW] : r_regs[w_sel];
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .rd_sel_i     (rd_sel_i),
        .rd_busy_o    (rd_busy_o),
        .wr_en_i      (wr_en_i),
        .wr_sel_i     (wr_sel_i),
        .sb_set_en_i  (sb_set_en_i),
        .sb_set_sel_i (sb_set_sel_i),
        .sb_flush_i   (sb_flush_i),
        .busy_vec_o   (busy_vec_o)
    );
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: scoreboard-driven bench for rf_mp (default config and a 4-read, no-zero-register config).
module tb_rf_mp;
    import rf_pkg::*;
    localparam int AW = RF_AW;
    localparam int DW = RF_DW;
    localparam int N  = RF_DEPTH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2*AW-1:0] rd_sel = '0;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_busy;
    logic [4*AW-1:0] rd_sel4 = '0;
    logic [4*DW-1:0] rd_data4;
    logic [3:0]      rd_busy4;
    logic [1:0]      wr_en = '0;
    logic [2*AW-1:0] wr_sel = '0;
    logic [2*DW-1:0] wr_data = '0;
    logic            sb_set_en = 1'b0;
    logic [AW-1:0]   sb_set_sel = '0;
    logic            sb_flush = 1'b0;
    logic [N-1:0]    busy_vec;
    logic [N-1:0]    busy_vec4;

    logic [DW-1:0] m_reg  [N];
    logic [DW-1:0] m_reg4 [N];
    logic [N-1:0]  m_busy;
    logic [DW-1:0] q_exp [$];
    logic [DW-1:0] exp_v;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_mp #(.NUM_RD(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
        .rd_busy_o(rd_busy), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
        .sb_set_en_i(sb_set_en), .sb_set_sel_i(sb_set_sel), .sb_flush_i(sb_flush),
        .busy_vec_o(busy_vec)
    );

    rf_mp #(.NUM_RD(4), .ZERO_REG(0)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .rd_sel_i(rd_sel4), .rd_data_o(rd_data4),
        .rd_busy_o(rd_busy4), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
        .sb_set_en_i(sb_set_en), .sb_set_sel_i(sb_set_sel), .sb_flush_i(sb_flush),
        .busy_vec_o(busy_vec4)
    );

    task automatic idle();
        wr_en = '0;
        sb_set_en = 1'b0;
        sb_flush = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_reg[i] = '0;
            m_reg4[i] = '0;
        end
        m_busy = '0;
    endtask

    // Advance one clock, updating the reference model from the inputs being applied.
    task automatic tick();
        logic [AW-1:0] idx;
        for (int p = 0; p < 2; p++)
            if (wr_en[p]) begin
                idx = wr_sel[p*AW +: AW];
                m_reg4[idx] = wr_data[p*DW +: DW];
                if (idx != 0) m_reg[idx] = wr_data[p*DW +: DW];
                m_busy[idx] = 1'b0;
            end
        if (sb_set_en && sb_set_sel != 0) m_busy[sb_set_sel] = 1'b1;
        if (sb_flush) m_busy = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (rd_data !== '0 || busy_vec !== '0) begin
            errors++;
            $display("FAIL reset_init rd_data=%h busy_vec=%h exp=0", rd_data, busy_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        for (int i = 1; i < N; i += 2) begin
            wr_en = (i < N - 1) ? 2'b11 : 2'b01;
            wr_sel = {AW'(i + 1), AW'(i)};
            wr_data = {$urandom(), $urandom() | 32'h1};
            tick();
        end
        idle();
        sb_set_en = 1'b1;
        sb_set_sel = 5;
        tick();
        sb_set_sel = 17;
        tick();
        idle();
        q_exp.push_back(m_busy);
        checks++;
        exp_v = q_exp.pop_front();
        if (busy_vec !== exp_v) begin
            errors++;
            $display("FAIL preload_busy got=%h exp=%h", busy_vec, exp_v);
        end
        rd_sel = {AW'(9), AW'(7)};
        q_exp.push_back(m_reg[7]);
        #1;
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data[0 +: DW] !== exp_v) begin
            errors++;
            $display("FAIL preload_read got=%h exp=%h", rd_data[0 +: DW], exp_v);
        end
        wr_en = 2'b01;
        wr_sel = {AW'(0), AW'(7)};
        wr_data = {32'h0, 32'hAAAA5555};
        sb_set_en = 1'b1;
        sb_set_sel = 9;
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_vec !== '0 || rd_data4 !== '0) begin
            errors++;
            $display("FAIL reset_async rd_data=%h rd_busy=%b busy_vec=%h exp=0", rd_data, rd_busy, busy_vec);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            rd_sel = {AW'(i), AW'(i)};
            rd_sel4 = {4{AW'(i)}};
            q_exp.push_back(m_reg[i]);
            q_exp.push_back(m_reg4[i]);
            #1;
            checks++;
            exp_v = q_exp.pop_front();
            if (rd_data[DW +: DW] !== exp_v || rd_data[0 +: DW] !== exp_v) begin
                errors++;
                $display("FAIL reset_read idx=%0d got=%h exp=%h", i, rd_data, exp_v);
            end
            checks++;
            exp_v = q_exp.pop_front();
            if (rd_data4[3*DW +: DW] !== exp_v) begin
                errors++;
                $display("FAIL reset_read4 idx=%0d got=%h exp=%h", i, rd_data4[3*DW +: DW], exp_v);
            end
        end
        checks++;
        if (busy_vec !== '0) begin
            errors++;
            $display("FAIL reset_busy got=%h exp=0", busy_vec);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        rd_sel = {AW'(0), AW'(5)};
        wr_en = 2'b01;
        wr_sel = {AW'(0), AW'(5)};
        wr_data = {32'h0, 32'hDEADBEEF};
        q_exp.push_back(32'hDEADBEEF);
        #1;
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data[0 +: DW] !== exp_v) begin
            errors++;
            $display("FAIL bypass_same got=%h exp=%h", rd_data[0 +: DW], exp_v);
        end
        tick();
        idle();
        q_exp.push_back(32'hDEADBEEF);
        #1;
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data[0 +: DW] !== exp_v) begin
            errors++;
            $display("FAIL bypass_after got=%h exp=%h", rd_data[0 +: DW], exp_v);
        end
    endtask

    task automatic test_collision();
        rd_sel = {AW'(7), AW'(7)};
        rd_sel4 = {4{AW'(7)}};
        wr_en = 2'b11;
        wr_sel = {AW'(7), AW'(7)};
        wr_data = {32'h22222222, 32'h11111111};
        q_exp.push_back(32'h22222222);
        #1;
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data[0 +: DW] !== exp_v || rd_data[DW +: DW] !== exp_v) begin
            errors++;
            $display("FAIL collision_same got=%h exp=%h", rd_data, exp_v);
        end
        tick();
        idle();
        q_exp.push_back(32'h22222222);
        #1;
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data[0 +: DW] !== exp_v || rd_data4[2*DW +: DW] !== exp_v) begin
            errors++;
            $display("FAIL collision_after got=%h/%h exp=%h", rd_data[0 +: DW], rd_data4[2*DW +: DW], exp_v);
        end
    endtask

    task automatic test_zero_reg();
        rd_sel = '0;
        rd_sel4 = '0;
        wr_en = 2'b01;
        wr_sel = '0;
        wr_data = {32'h0, 32'hFFFFFFFF};
        sb_set_en = 1'b1;
        sb_set_sel = 0;
        q_exp.push_back(32'h0);
        q_exp.push_back(32'hFFFFFFFF);
        #1;
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data[0 +: DW] !== exp_v) begin
            errors++;
            $display("FAIL zero_bypass got=%h exp=%h", rd_data[0 +: DW], exp_v);
        end
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data4[0 +: DW] !== exp_v) begin
            errors++;
            $display("FAIL nozero_bypass got=%h exp=%h", rd_data4[0 +: DW], exp_v);
        end
        tick();
        idle();
        q_exp.push_back(m_reg[0]);
        q_exp.push_back(m_reg4[0]);
        #1;
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data[0 +: DW] !== exp_v || busy_vec[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_after got=%h busy0=%b exp=%h busy0=0", rd_data[0 +: DW], busy_vec[0], exp_v);
        end
        checks++;
        exp_v = q_exp.pop_front();
        if (rd_data4[0 +: DW] !== exp_v) begin
            errors++;
            $display("FAIL nozero_after got=%h exp=%h", rd_data4[0 +: DW], exp_v);
        end
    endtask

    task automatic test_scoreboard();
        sb_set_en = 1'b1;
        sb_set_sel = 9;
        tick();
        idle();
        rd_sel = {AW'(9), AW'(0)};
        #1;
        checks++;
        if (busy_vec[9] !== 1'b1 || rd_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set busy9=%b rd_busy1=%b exp=1/1", busy_vec[9], rd_busy[1]);
        end
        wr_en = 2'b01;
        wr_sel = {AW'(0), AW'(9)};
        wr_data = {32'h0, 32'h99999999};
        #1;
        checks++;
        if (rd_busy[1] !== 1'b0 || busy_vec[9] !== 1'b1) begin
            errors++;
            $display("FAIL sb_wb_same rd_busy1=%b busy9=%b exp=0/1", rd_busy[1], busy_vec[9]);
        end
        tick();
        idle();
        checks++;
        if (busy_vec[9] !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear got=%b exp=0", busy_vec[9]);
        end
        sb_set_en = 1'b1;
        sb_set_sel = 9;
        wr_en = 2'b10;
        wr_sel = {AW'(9), AW'(0)};
        wr_data = {32'h12345678, 32'h0};
        tick();
        idle();
        q_exp.push_back(m_busy);
        checks++;
        exp_v = q_exp.pop_front();
        if (busy_vec[9] !== 1'b1 || busy_vec !== exp_v) begin
            errors++;
            $display("FAIL sb_set_beats_clear got=%h exp=%h", busy_vec, exp_v);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            sb_set_en = 1'b1;
            sb_set_sel = (i == 0) ? AW'(3) : (i == 1) ? AW'(4) : AW'(8);
            tick();
        end
        idle();
        q_exp.push_back(32'h0000_0318);
        checks++;
        exp_v = q_exp.pop_front();
        if (busy_vec !== exp_v) begin
            errors++;
            $display("FAIL flush_pre got=%h exp=%h", busy_vec, exp_v);
        end
        sb_flush = 1'b1;
        sb_set_en = 1'b1;
        sb_set_sel = 10;
        tick();
        idle();
        checks++;
        if (busy_vec !== '0 || m_busy !== '0) begin
            errors++;
            $display("FAIL flush got=%h exp=0", busy_vec);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) begin
            wr_en = i[0] ? 2'b10 : 2'b01;
            wr_sel = {AW'(i), AW'(i)};
            wr_data = {$urandom(), $urandom()};
            tick();
        end
        idle();
        for (int j = 0; j < N; j += 4) begin
            rd_sel4 = {AW'(j + 3), AW'(j + 2), AW'(j + 1), AW'(j)};
            rd_sel = {AW'(j + 1), AW'(j)};
            for (int k = 0; k < 4; k++) q_exp.push_back(m_reg4[j + k]);
            for (int k = 0; k < 2; k++) q_exp.push_back(m_reg[j + k]);
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                exp_v = q_exp.pop_front();
                if (rd_data4[k*DW +: DW] !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_read4 idx=%0d got=%h exp=%h", j + k, rd_data4[k*DW +: DW], exp_v);
                end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                exp_v = q_exp.pop_front();
                if (rd_data[k*DW +: DW] !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_read idx=%0d got=%h exp=%h", j + k, rd_data[k*DW +: DW], exp_v);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised multi-port register file for the Decode stage. Successor to the 2-read/1-write `rf`.
- Configurable data width, depth and read-port count.
- Two write ports with fixed priority, plus write-first bypass to all read ports.
- Optional hardwired-zero register 0.
- Per-register busy scoreboard, set at issue and cleared at write-back, so decode can detect RAW hazards.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of 2, ≥ 2.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, if 1 register 0 reads 0, ignores writes and is never busy.
- AW, $clog2(DEPTH), derived index width; must not be overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset: one clock; reset is asynchronous and active-low.
- rd_sel_i  in  NUM_RD*AW  read indices; port k occupies bits [k*AW +: AW].
- rd_data_o  out  NUM_RD*DW  read data; port k occupies bits [k*DW +: DW].
- rd_busy_o  out  NUM_RD  port k's register is pending (scoreboard view).
- wr_en_i  in  2  write enable per write port.
- wr_sel_i  in  2*AW  write destination per write port.
- wr_data_i  in  2*DW  write data per write port.
- sb_set_en_i  in  1  mark a register pending (instruction issued).
- sb_set_sel_i  in  AW  register to mark pending.
- sb_flush_i  in  1  synchronously clear every busy bit (pipeline flush).
- busy_vec_o  out  DEPTH  registered busy bits, bit i belongs to register i.

Behaviour:
- Reset (asynchronous, any time, including mid-write): all registers become 0 and all busy bits become 0. Consequently rd_data_o = 0, rd_busy_o = 0 and busy_vec_o = 0 for as long as rst_n_i = 0. Writes and sets are ignored while reset is asserted.
- Write: on the rising edge, reg[wr_sel[p]] <= wr_data[p] for each p with wr_en[p] = 1.
  - If both ports target the same index, port 1 wins.
  - Distinct indices are both written in the same cycle.
- Read: combinational, zero latency. rd_data[k] = reg[rd_sel[k]], unless bypassed.
- Bypass (write-first): if any wr_en[p] and wr_sel[p] == rd_sel[k], rd_data[k] = wr_data of the winning write port (port 1 if both match). The new value is therefore visible in the same cycle as the write.
- ZERO_REG = 1:
  - Writes to index 0 are dropped; reads of index 0 return 0 and are never bypassed.
  - sb_set to index 0 is ignored; busy_vec_o[0] is always 0.
- Scoreboard update, each rising edge, applied in priority order (highest first):
  1. sb_flush_i: all busy bits <= 0. Any simultaneous set is also discarded.
  2. Set: busy[sb_set_sel] <= 1. Set beats a clear of the same index in the same cycle, because a new producer has issued.
  3. Clear: each enabled write port clears busy[wr_sel[p]].
- rd_busy_o[k] = busy[rd_sel[k]] & ~(any wr_en[p] with wr_sel[p] == rd_sel[k]). A register being written back this cycle is therefore reported ready, consistent with the bypass.
- Setting an already-busy bit leaves it 1. Clearing a non-busy bit is a no-op.
- Out-of-range indices cannot occur, since DEPTH = 2^AW.
- No X on any output after reset, for any input combination.

Decomposition:
- Package rf_pkg:
  - Default constants RF_DW, RF_DEPTH, RF_AW.
  - typedefs rf_idx_t (logic [RF_AW-1:0]) and rf_data_t (logic [RF_DW-1:0]).
- Sub-module rf_scoreboard:
  - Owns the busy vector, the set/clear/flush priority logic and the rd_busy_o masking.
  - rf_mp contains the storage array, write arbitration and bypass muxes.

Test Plan:
- Reset: load registers 1..31 with random data, pulse rst_n_i low mid-cycle (not at a clock edge) → outputs go 0 immediately without waiting for a clock edge, all 32 registers read 0, busy_vec_o = 0.
- Bypass: wr_en = 01, wr_sel[0] = 5, data 0xDEADBEEF, rd_sel[0] = 5 in the same cycle → rd_data[0] = 0xDEADBEEF before the edge; after the edge, with writes disabled, still 0xDEADBEEF.
- Write collision: both ports write register 7 (port0 0x11111111, port1 0x22222222) → same-cycle read returns 0x22222222; next cycle register 7 holds 0x22222222.
- Zero register: write 0xFFFFFFFF to register 0 and sb_set register 0 → rd_data = 0, busy_vec_o[0] = 0. With ZERO_REG = 0 the same stimulus reads back 0xFFFFFFFF.
- Scoreboard:
  - Set register 9 → next cycle busy_vec_o[9] = 1 and rd_busy_o = 1 for a port reading 9.
  - Write register 9 → rd_busy_o = 0 in that same cycle, busy_vec_o[9] = 0 next cycle.
  - Set and write register 9 in the same cycle → busy_vec_o[9] stays 1.
- Flush: set registers 3, 4 and 8, then assert sb_flush_i together with a set of register 10 → busy_vec_o = 0 on the next cycle. Repeat the exhaustive write-then-read of all indices with NUM_RD = 4, checking against a model.
